// File: rtl/gpio_in_debounce.sv
// Purpose : two-flop synchroniser plus per-bit debounce for raw GPIO pins, with
//           rise/fall pulses, sticky write-1-to-clear change flags and a maskable level IRQ.
// Latency : a steady new pin value first captured by s1 at edge k is accepted at
//           edge k+1+DB_CYCLES (gpio_i, pulse, flag and irq_o all update together).
// Backpr. : none; pins are sampled every clock and nothing can stall the block.
//
// Ports:
//   clk       - system clock, rising edge
//   reset_n   - asynchronous active-low reset (release is synchronous to clk upstream)
//   pin_i     - raw asynchronous board pins
//   gpio_i    - debounced level, feeds the SoC gpio_i input
//   rise_o    - one-cycle pulse per bit on an accepted 0->1 change
//   fall_o    - one-cycle pulse per bit on an accepted 1->0 change
//   flag_o    - sticky per-bit change flags
//   clr_i     - per-bit write-1-to-clear strobe for flag_o (an event that cycle wins)
//   irq_en_i  - per-bit interrupt enable
//   irq_o     - registered level interrupt: any enabled flag set
module gpio_in_debounce #(
  parameter int                 WIDTH     = 8,
  parameter int                 DB_CYCLES = 16,
  parameter logic [WIDTH-1:0]   INIT      = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] flag_o,
  input  logic [WIDTH-1:0] clr_i,
  input  logic [WIDTH-1:0] irq_en_i,
  output logic             irq_o
);

  localparam int             CW      = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  // Synchroniser chain
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;

  // Debounce state
  logic [WIDTH-1:0]         stable_q, stable_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

  // Event outputs
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic             irq_q, irq_d;

  // Per-bit update event for the current cycle
  logic [WIDTH-1:0] upd;

  always_comb begin
    s1_d     = pin_i;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    rise_d   = '0;
    fall_d   = '0;
    upd      = '0;

    for (int b = 0; b < WIDTH; b++) begin
      if (s2_q[b] == stable_q[b]) begin
        // Agreeing sample: any count in progress was a glitch, discard it.
        cnt_d[b] = '0;
      end else if (cnt_q[b] == CNT_MAX) begin
        // DB_CYCLES consecutive differing samples: accept the new level.
        stable_d[b] = s2_q[b];
        cnt_d[b]    = '0;
        upd[b]      = 1'b1;
        rise_d[b]   = s2_q[b];
        fall_d[b]   = ~s2_q[b];
      end else begin
        cnt_d[b] = cnt_q[b] + CNT_ONE;
      end
    end

    // A new event overrides a simultaneous clear so no change is ever lost.
    flag_d = (flag_q & ~clr_i) | upd;

    // Built from flag_d so the request tracks the flag on the same edge.
    irq_d = |(flag_d & irq_en_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= INIT;
      s2_q     <= INIT;
      stable_q <= INIT;
      cnt_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      flag_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  assign gpio_i = stable_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign flag_o = flag_q;
  assign irq_o  = irq_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce with DB_CYCLES=4, WIDTH=8, INIT=0.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_gpio_in_debounce;

  logic       clk;
  logic       reset_n;
  logic [7:0] pin_i;
  logic [7:0] gpio_i;
  logic [7:0] rise_o;
  logic [7:0] fall_o;
  logic [7:0] flag_o;
  logic [7:0] clr_i;
  logic [7:0] irq_en_i;
  logic       irq_o;

  int checks   = 0;
  int failures = 0;

  gpio_in_debounce #(
    .WIDTH    (8),
    .DB_CYCLES(4),
    .INIT     (8'h00)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pin_i   (pin_i),
    .gpio_i  (gpio_i),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .flag_o  (flag_o),
    .clr_i   (clr_i),
    .irq_en_i(irq_en_i),
    .irq_o   (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all_flags();
    clr_i = 8'hFF;
    tick();
    clr_i = 8'h00;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (gpio_i !== 8'h00) begin failures++; $display("FAIL reset_gpio got=%h exp=%h", gpio_i, 8'h00); end
    checks++;
    if ({rise_o, fall_o, flag_o} !== 24'h0) begin failures++; $display("FAIL reset_evt got=%h exp=0", {rise_o, fall_o, flag_o}); end
    checks++;
    if (irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    reset_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({gpio_i, rise_o, fall_o, flag_o} !== 32'h0) begin failures++; $display("FAIL post_reset got=%h exp=0", {gpio_i, rise_o, fall_o, flag_o}); end
  endtask

  // pin_i[0] steps 0->1; edge k is the first edge after the change.
  task automatic test_clean_step();
    irq_en_i = 8'h01;
    pin_i[0] = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      tick();
      if (i < 5) begin
        checks++;
        if ({gpio_i, rise_o, flag_o, 7'h0, irq_o} !== 32'h0) begin
          failures++; $display("FAIL step_early i=%0d got=%h exp=0", i, {gpio_i, rise_o, flag_o, 7'h0, irq_o});
        end
      end else if (i == 5) begin
        checks++;
        if ({gpio_i, rise_o, flag_o, 7'h0, irq_o} !== 32'h01010101) begin
          failures++; $display("FAIL step_accept got=%h exp=%h", {gpio_i, rise_o, flag_o, 7'h0, irq_o}, 32'h01010101);
        end
      end else begin
        checks++;
        if ({gpio_i, rise_o, fall_o} !== 24'h010000) begin
          failures++; $display("FAIL step_pulse_width got=%h exp=%h", {gpio_i, rise_o, fall_o}, 24'h010000);
        end
      end
    end
    clear_all_flags();
    checks++;
    if ({flag_o, 7'h0, irq_o} !== 16'h0) begin failures++; $display("FAIL step_clear got=%h exp=0", {flag_o, 7'h0, irq_o}); end
    irq_en_i = 8'h00;
  endtask

  // pin_i[3] high for 3 clocks only: one sample short of acceptance.
  task automatic test_glitch();
    pin_i[3] = 1'b1;
    repeat (3) tick();
    pin_i[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({gpio_i, rise_o, fall_o, flag_o} !== 32'h01000000) begin
        failures++; $display("FAIL glitch i=%0d got=%h exp=%h", i, {gpio_i, rise_o, fall_o, flag_o}, 32'h01000000);
      end
    end
  endtask

  // pin_i[7] bounces 1,0,1,1,0 then holds 1: exactly one rise at k+5.
  task automatic test_bounce();
    logic [4:0] seq;
    seq = 5'b01101; // applied LSB first: 1,0,1,1,0
    for (int i = 0; i < 5; i++) begin
      pin_i[7] = seq[i];
      tick();
      checks++;
      if (rise_o !== 8'h00) begin failures++; $display("FAIL bounce_early i=%0d got=%h exp=0", i, rise_o); end
    end
    pin_i[7] = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      tick();
      checks++;
      if (rise_o !== ((i == 5) ? 8'h80 : 8'h00)) begin
        failures++; $display("FAIL bounce_rise i=%0d got=%h exp=%h", i, rise_o, (i == 5) ? 8'h80 : 8'h00);
      end
    end
    checks++;
    if ({gpio_i, flag_o} !== 16'h8180) begin failures++; $display("FAIL bounce_final got=%h exp=%h", {gpio_i, flag_o}, 16'h8180); end
    clear_all_flags();
  endtask

  // Clear arriving on the same edge as a new fall event on bit 2 must lose.
  task automatic test_clear_collision();
    irq_en_i = 8'h04;
    pin_i[2] = 1'b1;
    repeat (6) tick();
    checks++;
    if ({gpio_i, flag_o, 7'h0, irq_o} !== 24'h850401) begin
      failures++; $display("FAIL coll_set got=%h exp=%h", {gpio_i, flag_o, 7'h0, irq_o}, 24'h850401);
    end
    pin_i[2] = 1'b0;
    repeat (5) tick(); // edges k..k+4
    clr_i = 8'h04;
    tick();            // edge k+5: fall event and clear together
    clr_i = 8'h00;
    checks++;
    if ({gpio_i, fall_o, flag_o, 7'h0, irq_o} !== 32'h81040401) begin
      failures++; $display("FAIL coll_set_wins got=%h exp=%h", {gpio_i, fall_o, flag_o, 7'h0, irq_o}, 32'h81040401);
    end
    repeat (2) tick();
    clr_i = 8'h04;
    tick();
    clr_i = 8'h00;
    checks++;
    if ({flag_o, 7'h0, irq_o} !== 16'h0000) begin
      failures++; $display("FAIL coll_clear got=%h exp=0", {flag_o, 7'h0, irq_o});
    end
    irq_en_i = 8'h00;
  endtask

  task automatic test_mask();
    irq_en_i = 8'h00;
    pin_i[4] = 1'b1;
    repeat (6) tick();
    checks++;
    if ({flag_o, 7'h0, irq_o} !== 16'h1000) begin failures++; $display("FAIL mask_off got=%h exp=%h", {flag_o, 7'h0, irq_o}, 16'h1000); end
    irq_en_i = 8'h10;
    tick();
    checks++;
    if (irq_o !== 1'b1) begin failures++; $display("FAIL mask_on got=%b exp=1", irq_o); end
    irq_en_i = 8'h00;
    tick();
    checks++;
    if ({flag_o, 7'h0, irq_o} !== 16'h1000) begin failures++; $display("FAIL mask_drop got=%h exp=%h", {flag_o, 7'h0, irq_o}, 16'h1000); end
    clear_all_flags();
  endtask

  // Reset 2 clocks into a count on bit 1; pins 0,4,7 are also high, so after
  // release all four bits rise together exactly once.
  task automatic test_reset_mid_count();
    irq_en_i = 8'hFF;
    pin_i[1] = 1'b1;
    repeat (4) tick(); // edges k..k+3: cnt reaches 2
    checks++;
    if ({gpio_i, rise_o} !== 16'h9100) begin failures++; $display("FAIL midcnt_pre got=%h exp=%h", {gpio_i, rise_o}, 16'h9100); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({gpio_i, rise_o, fall_o, flag_o, 7'h0, irq_o} !== 40'h0) begin
      failures++; $display("FAIL midcnt_async got=%h exp=0", {gpio_i, rise_o, fall_o, flag_o, 7'h0, irq_o});
    end
    repeat (3) tick();
    reset_n = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      tick();
      checks++;
      if (rise_o !== ((i == 5) ? 8'h93 : 8'h00)) begin
        failures++; $display("FAIL midcnt_rise i=%0d got=%h exp=%h", i, rise_o, (i == 5) ? 8'h93 : 8'h00);
      end
    end
    checks++;
    if ({gpio_i, flag_o, 7'h0, irq_o} !== 24'h939301) begin
      failures++; $display("FAIL midcnt_final got=%h exp=%h", {gpio_i, flag_o, 7'h0, irq_o}, 24'h939301);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    pin_i    = 8'h00;
    clr_i    = 8'h00;
    irq_en_i = 8'h00;
    test_reset();
    test_clean_step();
    test_glitch();
    test_bounce();
    test_clear_collision();
    test_mask();
    test_reset_mid_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_in_debounce.md
# gpio_in_debounce

Input-conditioning stage that sits directly upstream of the `soc_6502` GPIO input port. It takes raw, asynchronous board pins and synchronises and debounces them per bit. The debounced level drives the SoC's `gpio_i`, and the block also produces rise/fall pulses, sticky change flags and a maskable interrupt for firmware. Everything runs in the single SoC clock domain.

## Interface
Parameters:
- `WIDTH`, 8, number of input pins (1..16).
- `DB_CYCLES`, 16, consecutive stable synchronised samples required to accept a new level (2..65536). Counter width is `$clog2(DB_CYCLES)`.
- `INIT`, 8'h00, reset value of the synchronisers and the debounced level (`WIDTH` bits).

Ports:
- `clk`, input, 1: system clock, rising-edge.
- `reset_n`, input, 1: asynchronous, active-low reset. It asserts immediately; release is applied synchronously to `clk` by the SoC reset logic.
- `pin_i`, input, `WIDTH`: raw asynchronous pins.
- `gpio_i`, output, `WIDTH`: debounced level, connects to the SoC `gpio_i`.
- `rise_o`, output, `WIDTH`: one-cycle pulse per bit on an accepted 0->1 change.
- `fall_o`, output, `WIDTH`: one-cycle pulse per bit on an accepted 1->0 change.
- `flag_o`, output, `WIDTH`: sticky change flags.
- `clr_i`, input, `WIDTH`: write-1-to-clear strobe for `flag_o`, one bit per flag.
- `irq_en_i`, input, `WIDTH`: per-bit interrupt enable.
- `irq_o`, output, 1: level interrupt request.

## Operation
- **Per bit, independent.** Synchroniser chain is `s1 <= pin_i`, `s2 <= s1`.
- **Debounce state.** Per bit: `stable` (drives `gpio_i`) and `cnt`.
- **Each clock:**
  - `s2 == stable`: `cnt <= 0`, no update.
  - `s2 != stable` and `cnt == DB_CYCLES-1`: `stable <= s2`, `cnt <= 0`, update event.
  - `s2 != stable` otherwise: `cnt <= cnt + 1`.
- **Glitches.** Any return of `s2` to `stable` before the count completes restarts the count from 0, so the glitch is discarded.
- **Edge pulses.** On an update event, `rise_o` is set if the new level is 1, otherwise `fall_o` is set; both are registered for one cycle. A bit never has `rise_o` and `fall_o` high together.
- **Flags.**
  - Set: `flag[b] <= 1` on any update event of bit b.
  - Clear: `flag[b] <= 0` when `clr_i[b]` is high and no event occurs on bit b that cycle.
  - Simultaneous event and clear: set wins.
- **Interrupt.** `irq_o` is registered: `irq_o <= |(flag_next & irq_en_i)`. Disabling an enable bit drops the request one cycle later without clearing the flag.
- **Reset (`reset_n` low).**
  - `s1`, `s2` and `stable` load `INIT`.
  - `cnt`, `rise_o`, `fall_o`, `flag_o` and `irq_o` load 0.
  - `gpio_i` therefore reads `INIT`.
  - Reset asserted mid-count abandons the count; no pulse or flag results.
- **Startup.** After reset release, a pin held at a value different from `INIT` is accepted as a normal change, producing one pulse and one flag set, after the latency below.

## Timing
- **Latency.** Let edge k be the first edge at which `s1` captures a new, steady pin value:
  - `s2` changes at edge k+1.
  - `stable`/`gpio_i`, the rise/fall pulse and the flag set all update at edge k+1+`DB_CYCLES`.
  - `irq_o` asserts at the same edge, since it is computed from `flag_next`.
- **Pulse width.** Pulses last exactly one clock.
- **Flag clear.** The flag clears at the edge that samples `clr_i`; `irq_o` drops at the same edge if no other enabled flag is set.
- **Throughput.** Minimum spacing between accepted changes on one bit is `DB_CYCLES` clocks.
- **Counter range.** `cnt` never exceeds `DB_CYCLES-1`; no wrap-around is possible.
- **Timing closure.** No combinational path from `pin_i` to any output. All outputs are registered; `irq_o` is registered from a `flag_next` term, which is purely internal. The block must close at the SoC clock on iCE40.

## Test plan
Bench configuration: `DB_CYCLES=4`, `WIDTH=8`, `INIT=0`, with `reset_n` pulsed low for 3 cycles.

- **Clean step.** `pin_i[0]` goes 0->1 before edge k -> `gpio_i[0]`=1, `rise_o[0]` high for 1 cycle, `flag_o`=8'h01 and (with `irq_en_i`=8'h01) `irq_o`=1, all at edge k+5. Nothing changes before then.
- **Glitch.** `pin_i[3]` is high for 3 clocks, then low -> `gpio_i`, `rise_o`, `fall_o` and `flag_o` stay 0 throughout.
- **Bounce.** `pin_i[7]` toggles 1,0,1,1,0 at one-clock intervals, then holds 1 -> exactly one `rise_o[7]` pulse, 5 clocks after the final steady 1 is first sampled.
- **Clear collision.** Flag set on bit 2, then `clr_i`=8'h04 asserted in the same cycle as a new `fall_o[2]` event -> `flag_o[2]` remains 1. A later `clr_i`=8'h04 with no event -> `flag_o[2]`=0, and `irq_o` drops at that edge.
- **Mask.** `flag_o`=8'h10 with `irq_en_i`=8'h00 -> `irq_o`=0. Setting `irq_en_i`=8'h10 -> `irq_o`=1 at the next edge.
- **Reset mid-count.** `pin_i[1]` rises, then `reset_n` is asserted 2 clocks into the count -> outputs reset immediately and asynchronously. After release, with the pin still high, there is exactly one `rise_o[1]` pulse at release+5 edges.
